// File: rtl/mem_port_arbiter.sv
// Two-client (fetch/mem) arbiter onto a single downstream memory port.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin contention instead of mem-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_request_enable,
    input  logic              freq_mode,
    input  logic [ADDR_W-1:0] freq_addr,
    input  logic [DATA_W-1:0] freq_wdata,
    input  logic [DATA_W/8-1:0] freq_wstrb,
    output logic              fetch_response_enable,
    output logic [DATA_W-1:0] fresp_data,
    input  logic              mem_request_enable,
    input  logic              mreq_mode,
    input  logic [ADDR_W-1:0] mreq_addr,
    input  logic [DATA_W-1:0] mreq_wdata,
    input  logic [DATA_W/8-1:0] mreq_wstrb,
    output logic              mem_response_enable,
    output logic [DATA_W-1:0] mresp_data,
    output logic              dram_request_enable,
    output logic              dreq_mode,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [DATA_W-1:0] dreq_wdata,
    output logic [DATA_W/8-1:0] dreq_wstrb,
    input  logic              dram_response_enable,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              busy,
    output logic              arb_err
);
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    req_t [1:0]        slot_q, slot_d;
    logic              own_q, own_d;
    req_t              dreq_q, dreq_d;
    logic              dreq_en_q, dreq_en_d;
    logic              fresp_en_q, fresp_en_d;
    logic              mresp_en_q, mresp_en_d;
    logic [DATA_W-1:0] fresp_q, fresp_d;
    logic [DATA_W-1:0] mresp_q, mresp_d;
    logic              err_q, err_d;

    req_t [1:0]        in_req;
    req_t [1:0]        cand_req;
    logic [1:0]        pulse, outst, bad, legal, cand;
    logic              win;

    // Index 0 is fetch, index 1 is mem; own_q/win use the same encoding.
    assign in_req[0] = '{freq_mode, freq_addr, freq_wdata, freq_wstrb};
    assign in_req[1] = '{mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};
    assign pulse = {mem_request_enable, fetch_request_enable};
    assign outst = (state_q == WAIT) ? {own_q, ~own_q} : 2'b00;
    assign bad   = pulse & (pend_q | outst);
    assign legal = pulse & ~bad;
    assign cand  = pend_q | legal;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;

    assign win = (&cand) ? ~rr_q : cand[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`else
    assign win = cand[1];
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand_req[i] = pend_q[i] ? slot_q[i] : in_req[i];
            slot_d[i]   = legal[i] ? in_req[i] : slot_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | legal;
        own_d      = own_q;
        dreq_d     = dreq_q;
        dreq_en_d  = 1'b0;
        fresp_en_d = 1'b0;
        mresp_en_d = 1'b0;
        fresp_d    = fresp_q;
        mresp_d    = mresp_q;
        err_d      = err_q | (|bad);
`ifdef ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dram_response_enable) err_d = 1'b1;
                if (|cand) begin
                    dreq_en_d   = 1'b1;
                    dreq_d      = cand_req[win];
                    own_d       = win;
                    pend_d[win] = 1'b0;
                    state_d     = WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_d        = win;
`endif
                end
            end
            WAIT: begin
                if (dram_response_enable) begin
                    state_d = IDLE;
                    if (own_q) begin
                        mresp_en_d = 1'b1;
                        mresp_d    = dresp_data;
                    end else begin
                        fresp_en_d = 1'b1;
                        fresp_d    = dresp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            slot_q     <= '0;
            own_q      <= 1'b0;
            dreq_q     <= '0;
            dreq_en_q  <= 1'b0;
            fresp_en_q <= 1'b0;
            mresp_en_q <= 1'b0;
            fresp_q    <= '0;
            mresp_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            own_q      <= own_d;
            dreq_q     <= dreq_d;
            dreq_en_q  <= dreq_en_d;
            fresp_en_q <= fresp_en_d;
            mresp_en_q <= mresp_en_d;
            fresp_q    <= fresp_d;
            mresp_q    <= mresp_d;
            err_q      <= err_d;
        end
    end

    assign dram_request_enable   = dreq_en_q;
    assign dreq_mode             = dreq_q.mode;
    assign dreq_addr             = dreq_q.addr;
    assign dreq_wdata            = dreq_q.wdata;
    assign dreq_wstrb            = dreq_q.wstrb;
    assign fetch_response_enable = fresp_en_q;
    assign mem_response_enable   = mresp_en_q;
    assign fresp_data            = fresp_q;
    assign mresp_data            = mresp_q;
    assign busy                  = (state_q == WAIT);
    assign arb_err               = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, routing, contention, violations, reset.
// Contention order expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_request_enable, freq_mode;
    logic [31:0] freq_addr, freq_wdata;
    logic [3:0]  freq_wstrb;
    logic        fetch_response_enable;
    logic [31:0] fresp_data;
    logic        mem_request_enable, mreq_mode;
    logic [31:0] mreq_addr, mreq_wdata;
    logic [3:0]  mreq_wstrb;
    logic        mem_response_enable;
    logic [31:0] mresp_data;
    logic        dram_request_enable, dreq_mode;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dram_response_enable;
    logic [31:0] dresp_data;
    logic        busy, arb_err;

    int checks = 0;
    int fails  = 0;

    logic [31:0] first_addr, second_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .fetch_request_enable(fetch_request_enable),
        .freq_mode(freq_mode), .freq_addr(freq_addr),
        .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
        .fetch_response_enable(fetch_response_enable),
        .fresp_data(fresp_data),
        .mem_request_enable(mem_request_enable),
        .mreq_mode(mreq_mode), .mreq_addr(mreq_addr),
        .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
        .mem_response_enable(mem_response_enable),
        .mresp_data(mresp_data),
        .dram_request_enable(dram_request_enable),
        .dreq_mode(dreq_mode), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
        .dram_response_enable(dram_response_enable),
        .dresp_data(dresp_data),
        .busy(busy), .arb_err(arb_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        fetch_request_enable = 1'b0;
        mem_request_enable   = 1'b0;
        dram_response_enable = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        clr();
        freq_mode = 0; freq_addr = 0; freq_wdata = 0; freq_wstrb = 0;
        mreq_mode = 0; mreq_addr = 0; mreq_wdata = 0; mreq_wstrb = 0;
        dresp_data = 0;
        do_reset();
        check("rst_dreq_en", {31'b0, dram_request_enable}, 0);
        check("rst_fresp_en", {31'b0, fetch_response_enable}, 0);
        check("rst_mresp_en", {31'b0, mem_response_enable}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_err", {31'b0, arb_err}, 0);
        check("rst_addr", dreq_addr, 0);

        // single fetch read
        fetch_request_enable = 1; freq_mode = 0; freq_addr = 32'h100;
        tick();
        clr();
        check("rd_dreq_en", {31'b0, dram_request_enable}, 1);
        check("rd_addr", dreq_addr, 32'h100);
        check("rd_mode", {31'b0, dreq_mode}, 0);
        check("rd_busy", {31'b0, busy}, 1);
        tick();
        check("rd_dreq_1cyc", {31'b0, dram_request_enable}, 0);
        dram_response_enable = 1; dresp_data = 32'hDEADBEEF;
        tick();
        clr();
        check("rd_fresp_en", {31'b0, fetch_response_enable}, 1);
        check("rd_fresp_data", fresp_data, 32'hDEADBEEF);
        check("rd_mresp_en", {31'b0, mem_response_enable}, 0);
        check("rd_busy_done", {31'b0, busy}, 0);
        tick();
        check("rd_fresp_1cyc", {31'b0, fetch_response_enable}, 0);

        // mem write, fields forwarded unchanged
        mem_request_enable = 1; mreq_mode = 1; mreq_addr = 32'h2000;
        mreq_wdata = 32'h12345678; mreq_wstrb = 4'hF;
        tick();
        clr();
        check("wr_dreq_en", {31'b0, dram_request_enable}, 1);
        check("wr_mode", {31'b0, dreq_mode}, 1);
        check("wr_addr", dreq_addr, 32'h2000);
        check("wr_wdata", dreq_wdata, 32'h12345678);
        check("wr_wstrb", {28'b0, dreq_wstrb}, 32'hF);
        dram_response_enable = 1; dresp_data = 32'h0;
        tick();
        clr();
        check("wr_mresp_en", {31'b0, mem_response_enable}, 1);
        check("wr_fresp_en", {31'b0, fetch_response_enable}, 0);
        tick();

        // contention: last grant was mem
`ifdef ARB_ROUND_ROBIN_EN
        first_addr = 32'h0; second_addr = 32'h40;
`else
        first_addr = 32'h40; second_addr = 32'h0;
`endif
        fetch_request_enable = 1; freq_mode = 0; freq_addr = 32'h0;
        mem_request_enable = 1; mreq_mode = 0; mreq_addr = 32'h40;
        tick();
        clr();
        check("ct_first_addr", dreq_addr, first_addr);
        tick();
        dram_response_enable = 1; dresp_data = 32'hA5A5A5A5;
        tick();
        clr();
        check("ct_resp_owner", {31'b0, mem_response_enable},
              {31'b0, first_addr == 32'h40});
        check("ct_no_req_r1", {31'b0, dram_request_enable}, 0);
        tick();
        check("ct_req_r2", {31'b0, dram_request_enable}, 1);
        check("ct_second_addr", dreq_addr, second_addr);
        dram_response_enable = 1; dresp_data = 32'h5A5A5A5A;
        tick();
        clr();
        check("ct_resp2_fetch", {31'b0, fetch_response_enable},
              {31'b0, second_addr == 32'h0});
        check("ct_err_clean", {31'b0, arb_err}, 0);
        tick();

        // violation: fetch pulse while its read is outstanding
        fetch_request_enable = 1; freq_addr = 32'h300;
        tick();
        check("vi_addr", dreq_addr, 32'h300);
        freq_addr = 32'h400;
        tick();
        clr();
        check("vi_err", {31'b0, arb_err}, 1);
        dram_response_enable = 1; dresp_data = 32'h55;
        tick();
        clr();
        check("vi_fresp_en", {31'b0, fetch_response_enable}, 1);
        check("vi_fresp_data", fresp_data, 32'h55);
        tick();
        tick();
        check("vi_no_reissue", {31'b0, dram_request_enable}, 0);
        check("vi_idle", {31'b0, busy}, 0);
        check("vi_last_addr", dreq_addr, 32'h300);

        // spurious response in IDLE
        do_reset();
        check("sp_err_rst", {31'b0, arb_err}, 0);
        dram_response_enable = 1; dresp_data = 32'h77;
        tick();
        clr();
        check("sp_err", {31'b0, arb_err}, 1);
        check("sp_fresp", {31'b0, fetch_response_enable}, 0);
        check("sp_mresp", {31'b0, mem_response_enable}, 0);

        // reset mid-transaction
        do_reset();
        fetch_request_enable = 1; freq_addr = 32'h500;
        tick();
        clr();
        check("rm_busy", {31'b0, busy}, 1);
        rstn = 1'b0;
        #1;
        check("rm_busy_async", {31'b0, busy}, 0);
        check("rm_dreq_async", {31'b0, dram_request_enable}, 0);
        tick();
        rstn = 1'b1;
        fetch_request_enable = 1; freq_addr = 32'h600;
        tick();
        clr();
        check("rm_new_req", {31'b0, dram_request_enable}, 1);
        check("rm_new_addr", dreq_addr, 32'h600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
